// File: rtl/code_converter_2421_to_ex3_pkg.sv
// Shared types and constants for the 2421 -> Excess-3 digit converter.
package code_converter_2421_to_ex3_pkg;

  typedef logic [3:0] digit_t;

  // The ten legal 2421 codewords, in digit order 0..9.
  localparam digit_t C2421_0 = 4'b0000;
  localparam digit_t C2421_1 = 4'b0001;
  localparam digit_t C2421_2 = 4'b0010;
  localparam digit_t C2421_3 = 4'b0011;
  localparam digit_t C2421_4 = 4'b0100;
  localparam digit_t C2421_5 = 4'b1011;
  localparam digit_t C2421_6 = 4'b1100;
  localparam digit_t C2421_7 = 4'b1101;
  localparam digit_t C2421_8 = 4'b1110;
  localparam digit_t C2421_9 = 4'b1111;

  localparam digit_t EX3_OFFSET   = 4'd3;
  localparam digit_t ILLEGAL_FILL = 4'b0000;

endpackage

// File: rtl/code_converter_2421_to_ex3_decode.sv
// Combinational 2421 -> Excess-3 decoder with a legal-code flag.
// Digits 0..4 share their 2421 and binary codes, so Excess-3 is code+3;
// digits 5..9 sit at code = digit+6, so Excess-3 is code-3 (mod 16).
module code2421_decode
  import code_converter_2421_to_ex3_pkg::*;
(
  input  logic [3:0] in_2421,
  output logic       legal,
  output logic [3:0] ex3
);

  // Case table over the ten legal codewords; everything else is illegal.
  always_comb begin
    legal = 1'b1;
    ex3   = ILLEGAL_FILL;
    unique case (in_2421)
      C2421_0, C2421_1, C2421_2, C2421_3, C2421_4:
        ex3 = in_2421 + EX3_OFFSET;
      C2421_5, C2421_6, C2421_7, C2421_8, C2421_9:
        ex3 = in_2421 - EX3_OFFSET;
      default: begin
        legal = 1'b0;
        ex3   = ILLEGAL_FILL;
      end
    endcase
  end

endmodule

// File: rtl/code_converter_2421_to_ex3.sv
// Registered 2421 -> Excess-3 converter with a saturating invalid-code counter.
module code_converter_2421_to_ex3
  import code_converter_2421_to_ex3_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [3:0]           in_2421,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [3:0]           out_ex3,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic                 dec_legal;
  logic [3:0]           dec_ex3;

  logic                 out_valid_d, out_valid_q;
  logic [3:0]           out_ex3_d,   out_ex3_q;
  logic                 out_err_d,   out_err_q;
  logic [ERR_CNT_W-1:0] err_count_d, err_count_q;

  code2421_decode u_decode (
    .in_2421 (in_2421),
    .legal   (dec_legal),
    .ex3     (dec_ex3)
  );

  // Next-state: capture on valid, hold data otherwise; clear beats increment.
  always_comb begin
    out_valid_d = in_valid;
    out_ex3_d   = out_ex3_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    if (in_valid) begin
      out_ex3_d = dec_ex3;
      out_err_d = ~dec_legal;
    end
    if (err_clr) begin
      err_count_d = '0;
    end else if (in_valid && !dec_legal && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // Output and counter registers; async reset drops any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ex3_q   <= 4'b0000;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ex3_q   <= out_ex3_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ex3   = out_ex3_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_code_converter_2421_to_ex3.sv
// Scoreboard bench: the driver pushes the expected post-edge state per cycle,
// a monitor pops and compares one entry after every clock edge.
module tb_code_converter_2421_to_ex3;

  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [3:0]    in_2421;
  logic          err_clr;
  logic          out_valid;
  logic [3:0]    out_ex3;
  logic          out_err;
  logic [CW-1:0] err_count;

  code_converter_2421_to_ex3 #(.ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_2421   (in_2421),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .out_ex3   (out_ex3),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int ex3;
    int err;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: digit d (0..9) is encoded by legal_codes[d]; Excess-3 is d+3.
  int legal_codes[10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
  int m_ex3 = 0;
  int m_err = 0;
  int m_cnt = 0;

  function automatic int digit_of(input int code);
    for (int d = 0; d < 10; d++)
      if (legal_codes[d] == code) return d;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle, driven on the falling edge; expected state queued.
  task automatic step(input int v, input int code, input int clr);
    int d;
    exp_t e;
    @(negedge clk);
    in_valid = v[0];
    in_2421  = code[3:0];
    err_clr  = clr[0];
    d = digit_of(code);
    if (v != 0) begin
      m_ex3 = (d >= 0) ? d + 3 : 0;
      m_err = (d >= 0) ? 0 : 1;
    end
    if (clr != 0) m_cnt = 0;
    else if (v != 0 && d < 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    e.v = v; e.ex3 = m_ex3; e.err = m_err; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_ex3"},   int'(out_ex3),   0);
    check({tag, "_err"},   int'(out_err),   0);
    check({tag, "_cnt"},   int'(err_count), 0);
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("out_valid", int'(out_valid), e.v);
      check("out_ex3",   int'(out_ex3),   e.ex3);
      check("out_err",   int'(out_err),   e.err);
      check("err_count", int'(err_count), e.cnt);
    end
  end

  initial begin
    int c;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_2421  = 4'b1111;
    err_clr  = 1'b0;

    // Reset held with a valid input present.
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    q.push_back('{0, 0, 0, 0});

    // Legal sweep.
    for (int d = 0; d < 10; d++) step(1, legal_codes[d], 0);

    // Illegal codes 0101..1010.
    for (int cc = 5; cc <= 10; cc++) step(1, cc, 0);
    step(0, 0, 0);
    @(posedge clk); #2;
    check("err_after_six_illegal", int'(err_count), 6);

    // Hold behaviour with in_valid low; illegal code ignored.
    step(1, 3, 0);
    step(0, 3, 0);
    step(0, 7, 0);
    step(0, 9, 0);

    // Saturation, then clear beating a simultaneous illegal input.
    for (int i = 0; i < 300; i++) step(1, $urandom_range(10, 5), 0);
    step(0, 0, 0);
    @(posedge clk); #2;
    check("err_saturated", int'(err_count), CNT_MAX);
    step(1, 6, 1);
    step(0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 250; i++) begin
      c = $urandom_range(15, 0);
      step(($urandom_range(3, 0) != 0) ? 1 : 0, c,
           ($urandom_range(31, 0) == 0) ? 1 : 0);
    end

    // Asynchronous reset mid-sweep.
    step(1, 12, 0);
    step(1, 11, 0);
    @(posedge clk); #3;
    check("pre_reset_valid", int'(out_valid), 1);
    check("pre_reset_ex3",   int'(out_ex3),   8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    m_ex3 = 0; m_err = 0; m_cnt = 0;
    in_valid = 1'b1;
    in_2421  = 4'b0101;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("rst_mid");
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    q.push_back('{0, 0, 0, 0});
    step(0, 0, 0);
    step(1, 14, 0);
    step(1, 8, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    @(posedge clk); #3;
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
